// File: rtl/frame_receiver.sv
// rtl/frame_receiver.sv - assembles checksummed display frames from a UART byte stream
//
// Collects NUM_BYTES payload bytes plus one additive checksum byte. Frames are
// delimited by GAP_CYCLES idle cycles. A good frame is published atomically on
// data. The bus blanks to zero after STALE_CYCLES without a committed frame.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   rx_valid   one-cycle strobe, rx_data holds a received byte
//   rx_data    received byte
//   rx_err     one-cycle strobe, UART framing/parity error on the current byte
//   data       published frame, data[0] is the first byte on the wire
//   frame_stb  one-cycle pulse, new frame committed to data
//   err_stb    one-cycle pulse, frame rejected (checksum, truncation, rx_err)
//   stale      1 while no good frame has arrived within STALE_CYCLES (data is zero)

module frame_receiver #(
    parameter int NUM_BYTES    = 20,
    parameter int GAP_CYCLES   = 50_000,
    parameter int STALE_CYCLES = 50_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    input  logic                      rx_err,
    output logic [NUM_BYTES-1:0][7:0] data,
    output logic                      frame_stb,
    output logic                      err_stb,
    output logic                      stale
);

    localparam int IDX_W   = $clog2(NUM_BYTES + 1);
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam int STALE_W = $clog2(STALE_CYCLES + 1);

    typedef enum logic [1:0] {
        DISCARD,
        IDLE,
        RECV
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          idx_next;
    logic [IDX_W-1:0]          wr_idx;
    logic [7:0]                sum;
    logic [7:0]                sum_next;
    logic [GAP_W-1:0]          gap_cnt;
    logic [STALE_W-1:0]        stale_cnt;
    logic [NUM_BYTES-1:0][7:0] shadow;

    logic activity;
    logic gap_expire;
    logic stale_expire;
    logic shadow_we;
    logic commit;
    logic reject;

    assign activity = rx_valid || rx_err;

    // Expiry fires in the cycle whose edge brings gap_cnt to GAP_CYCLES, so a
    // byte arriving right after GAP_CYCLES idle cycles is already accepted.
    // The >= keeps DISCARD from getting stuck if the counter is already saturated.
    assign gap_expire   = !activity && (gap_cnt >= GAP_W'(GAP_CYCLES - 1));
    assign stale_expire = stale_cnt >= STALE_W'(STALE_CYCLES - 1);

    always_comb begin
        state_next = state;
        idx_next   = idx;
        sum_next   = sum;
        wr_idx     = idx;
        shadow_we  = 1'b0;
        commit     = 1'b0;
        reject     = 1'b0;
        case (state)
            DISCARD: begin
                if (gap_expire) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (rx_err) begin
                    state_next = DISCARD;
                end else if (rx_valid) begin
                    wr_idx     = '0;
                    shadow_we  = 1'b1;
                    sum_next   = rx_data;
                    idx_next   = IDX_W'(1);
                    state_next = RECV;
                end
            end
            RECV: begin
                // rx_err has priority over a byte presented in the same cycle.
                if (rx_err) begin
                    reject     = 1'b1;
                    state_next = DISCARD;
                end else if (rx_valid) begin
                    if (idx == IDX_W'(NUM_BYTES)) begin
                        if (rx_data == sum) begin
                            commit = 1'b1;
                        end else begin
                            reject = 1'b1;
                        end
                        state_next = DISCARD;
                    end else begin
                        shadow_we = 1'b1;
                        sum_next  = sum + rx_data;
                        idx_next  = idx + IDX_W'(1);
                    end
                end else if (gap_expire) begin
                    reject     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = DISCARD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DISCARD;
            idx       <= '0;
            sum       <= '0;
            gap_cnt   <= '0;
            stale_cnt <= '0;
            shadow    <= '0;
            data      <= '0;
            frame_stb <= 1'b0;
            err_stb   <= 1'b0;
            stale     <= 1'b1;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            sum       <= sum_next;
            frame_stb <= commit;
            err_stb   <= reject;

            if (activity) begin
                gap_cnt <= '0;
            end else if (gap_cnt != GAP_W'(GAP_CYCLES)) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end

            if (commit) begin
                stale_cnt <= '0;
            end else if (stale_cnt != STALE_W'(STALE_CYCLES)) begin
                stale_cnt <= stale_cnt + STALE_W'(1);
            end

            for (int i = 0; i < NUM_BYTES; i++) begin
                if (shadow_we && (wr_idx == IDX_W'(i))) begin
                    shadow[i] <= rx_data;
                end
            end

            // A commit landing on the stale expiry cycle takes precedence.
            if (commit) begin
                data  <= shadow;
                stale <= 1'b0;
            end else if (stale_expire) begin
                data  <= '0;
                stale <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_receiver.sv
// tb/tb_frame_receiver.sv - scoreboard bench for frame_receiver

module tb_frame_receiver;

    localparam int NB    = 20;
    localparam int GAP   = 8;
    localparam int STALE = 200;

    typedef logic [NB-1:0][7:0] frame_t;

    typedef struct {
        bit     is_err;
        frame_t data;
        bit     stale;
        int     exp_cyc;
        int     tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_err = 1'b0;
    frame_t     data;
    logic       frame_stb;
    logic       err_stb;
    logic       stale;

    int     cyc = 0;
    int     n_assert = 0;
    int     n_fail = 0;
    exp_t   q[$];
    frame_t model_data = '0;
    bit     model_stale = 1'b1;

    frame_receiver #(
        .NUM_BYTES   (NB),
        .GAP_CYCLES  (GAP),
        .STALE_CYCLES(STALE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_err   (rx_err),
        .data     (data),
        .frame_stb(frame_stb),
        .err_stb  (err_stb),
        .stale    (stale)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: every strobe must match the oldest expectation, in the right cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_stb || err_stb) begin
                n_assert++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe: frame_stb=%0b err_stb=%0b at cycle %0d, required none",
                             frame_stb, err_stb, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (frame_stb !== !e.is_err || err_stb !== e.is_err || cyc != e.exp_cyc ||
                        data !== e.data || stale !== e.stale) begin
                        n_fail++;
                        $display("FAIL strobe_%0d: got frame_stb=%0b err_stb=%0b cyc=%0d stale=%0b data=%h, required frame_stb=%0b err_stb=%0b cyc=%0d stale=%0b data=%h",
                                 e.tag, frame_stb, err_stb, cyc, stale, data,
                                 !e.is_err, e.is_err, e.exp_cyc, e.stale, e.data);
                    end
                end
            end else if (q.size() != 0 && cyc > q[0].exp_cyc) begin
                exp_t e;
                e = q.pop_front();
                n_assert++;
                n_fail++;
                $display("FAIL missed_strobe_%0d: no strobe by cycle %0d, required at cycle %0d",
                         e.tag, cyc, e.exp_cyc);
            end
        end
    end

    task automatic chk(input string name, input logic [NB*8-1:0] act, input logic [NB*8-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e);
        rx_valid = 1'b1;
        rx_data  = b;
        rx_err   = e;
        step();
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic expect_ev(input bit is_err, input frame_t f, input int exp_cyc, input int tag);
        exp_t e;
        e.is_err  = is_err;
        e.exp_cyc = exp_cyc;
        e.tag     = tag;
        if (!is_err) begin
            model_data  = f;
            model_stale = 1'b0;
        end
        e.data  = model_data;
        e.stale = model_stale;
        q.push_back(e);
    endtask

    // kind: 0 = no strobe expected, 1 = commit, 2 = reject
    task automatic send_frame(input frame_t f, input logic [7:0] chk_byte, input int kind, input int tag);
        if (kind != 0) expect_ev(kind == 2, f, cyc + NB + 1, tag);
        for (int i = 0; i < NB; i++) send_byte(f[i], 1'b0);
        send_byte(chk_byte, 1'b0);
    endtask

    function automatic frame_t make_frame(input int kind);
        frame_t f;
        for (int i = 0; i < NB; i++) begin
            case (kind)
                0:       f[i] = 8'(i + 1);        // 0x01..0x14, sum 0xD2
                1:       f[i] = 8'(8'hA0 + i);    // 0xA0..0xB3, sum 0x3E
                2:       f[i] = 8'hFF;            // all ones,   sum 0xEC
                default: f[i] = 8'(i * 17);       // i*0x11,     sum 0x9E
            endcase
        end
        return f;
    endfunction

    initial begin
        frame_t fa, fb, fc, fd;
        fa = make_frame(0);
        fb = make_frame(1);
        fc = make_frame(2);
        fd = make_frame(3);

        // Reset state
        rst = 1'b1;
        idle(2);
        chk("reset_data", data, '0);
        chk("reset_frame_stb", NB*8'(frame_stb), '0);
        chk("reset_err_stb", NB*8'(err_stb), '0);
        chk("reset_stale", NB*8'(stale), NB*8'(1));
        rst = 1'b0;

        // 1: good frame after exactly GAP idle cycles
        idle(GAP);
        send_frame(fa, 8'hD2, 1, 1);
        idle(1);
        chk("t1_data0", NB*8'(data[0]), NB*8'(8'h01));
        chk("t1_data19", NB*8'(data[19]), NB*8'(8'h14));
        chk("t1_stale", NB*8'(stale), '0);

        // 2: bad checksum
        idle(GAP);
        send_frame(fa, 8'hD3, 2, 2);
        idle(1);
        chk("t2_data_kept", data, fa);

        // 3: truncated frame, then a good frame
        idle(GAP);
        expect_ev(1'b1, '0, cyc + 10 + GAP, 3);
        for (int i = 0; i < 10; i++) send_byte(fb[i], 1'b0);
        idle(GAP);
        send_frame(fb, 8'h3E, 1, 4);

        // 4: rx_err (with rx_valid) on byte 5, rest of frame ignored
        idle(GAP);
        expect_ev(1'b1, '0, cyc + 5, 5);
        for (int i = 0; i < NB; i++) send_byte(fc[i], i == 4);
        send_byte(8'hEC, 1'b0);
        idle(2);
        chk("t4_data_kept", data, fb);
        idle(GAP);
        send_frame(fc, 8'hEC, 1, 6);

        // 5a: stale expiry after STALE cycles without a commit
        idle(GAP);
        send_frame(fa, 8'hD2, 1, 7);
        idle(STALE - 1);
        chk("t5_stale_before", NB*8'(stale), '0);
        chk("t5_data_before", data, fa);
        idle(1);
        chk("t5_stale_after", NB*8'(stale), NB*8'(1));
        chk("t5_data_blank", data, '0);
        model_data  = '0;
        model_stale = 1'b1;

        // 5b: commit on the very cycle the stale counter expires
        idle(GAP);
        send_frame(fb, 8'h3E, 1, 8);
        idle(STALE - NB - 1);
        send_frame(fd, 8'h9E, 1, 9);
        idle(1);
        chk("t5b_stale", NB*8'(stale), '0);
        chk("t5b_data", data, fd);
        idle(2);

        // 6: frame starting right after reset is ignored, retry after gap commits
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        model_data  = '0;
        model_stale = 1'b1;
        chk("t6_reset_data", data, '0);
        idle(1);
        send_frame(fa, 8'hD2, 0, 10);
        idle(1);
        chk("t6_ignored_stale", NB*8'(stale), NB*8'(1));
        chk("t6_ignored_data", data, '0);
        idle(GAP - 1);
        send_frame(fa, 8'hD2, 1, 11);
        idle(3);
        chk("t6_data", data, fa);

        chk("queue_drained", NB*8'(q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
